// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) to affine (X/Z^2, Y/Z^3) over GF(p) using a binary extended-Euclid inverter and two modular multipliers.
// Optional macro JAC2AFF_INV_CHECK_EN: multiplier 1 verifies Z*zinv == 1 in MUL_A and flags o_err on mismatch.

module modular_multiplication (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
  input  logic [255:0] i_p,
  output logic         o_ready,
  output logic [255:0] o_result
);
  localparam int DATA_W = 256;

  logic              r_busy;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_p;
  logic              w_load;

  // One MSB-first double-and-add step; acc and a are both already reduced below p.
  function automatic logic [DATA_W-1:0] mac_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic              bit_in,
                                                 input logic [DATA_W-1:0] pm);
    logic [DATA_W+1:0] t;
    t = {2'b00, acc} << 1;
    if (t >= {2'b00, pm}) t = t - {2'b00, pm};
    if (bit_in) t = t + {2'b00, a};
    if (t >= {2'b00, pm}) t = t - {2'b00, pm};
    return t[DATA_W-1:0];
  endfunction

  assign w_load   = i_start && !r_busy;
  assign o_ready  = !r_busy;
  assign o_result = r_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_busy <= 1'b1;
      r_cnt  <= 8'd255;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 8'd1;
      if (r_cnt == 8'd0) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_acc <= '0;
      r_a   <= i_a;
      r_b   <= i_b;
      r_p   <= i_p;
    end else if (r_busy) begin
      r_acc <= mac_step(r_acc, r_a, r_b[DATA_W-1], r_p);
      r_b   <= r_b << 1;
    end
  end
endmodule

module jacobian_to_affine (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [255:0] X,
  input  logic [255:0] Y,
  input  logic [255:0] Z,
  input  logic [255:0] p,
  output logic [255:0] x_aff,
  output logic [255:0] y_aff,
  output logic         o_inf,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);
  localparam int DATA_W = 256;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_INV, S_MUL_A, S_WAIT_A, S_MUL_B, S_WAIT_B, S_MUL_C, S_WAIT_C, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic              r_start_q, r_start_edge, r_skip;
  logic [DATA_W-1:0] r_X, r_Y, r_Z, r_p;
  logic [DATA_W-1:0] r_u, r_v, r_x1, r_x2;
  logic [DATA_W-1:0] r_zinv, r_zi2, r_zi3;
  logic              w_accept, w_take_a, w_take_b, w_take_c;
  logic              w_m0_start, w_m1_start, w_m0_rdy, w_m1_rdy;
  logic [DATA_W-1:0] w_m0_a, w_m0_b, w_m1_a, w_m1_b, w_m0_res, w_m1_res;

  // x/2 mod p for odd p; the odd case needs the 257-bit sum before shifting.
  function automatic logic [DATA_W-1:0] half_mod(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] pm);
    logic [DATA_W:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, pm} : {(DATA_W+1){1'b0}});
    return s[DATA_W:1];
  endfunction

  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] pm);
    logic [DATA_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DATA_W]) d = d + {1'b0, pm};
    return d[DATA_W-1:0];
  endfunction

  assign w_accept = r_start_edge && (r_state == S_IDLE || r_state == S_DONE);
  assign w_take_a = (r_state == S_WAIT_A) && (w_next == S_MUL_B);
  assign w_take_b = (r_state == S_WAIT_B) && (w_next == S_MUL_C);
  assign w_take_c = (r_state == S_WAIT_C) && (w_next == S_DONE);
  assign o_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done   = (r_state == S_DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start_q    <= 1'b0;
      r_start_edge <= 1'b0;
    end else begin
      r_start_q    <= i_start;
      r_start_edge <= i_start & ~r_start_q;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_m0_start = 1'b0;
    w_m1_start = 1'b0;
    w_m0_a     = r_zinv;
    w_m0_b     = r_zinv;
    w_m1_a     = r_zi2;
    w_m1_b     = r_zinv;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CHK;
      S_CHK:    w_next = (r_Z == '0) ? S_DONE : S_INV;
      S_INV:    if (r_u == 256'd1 || r_v == 256'd1) w_next = S_MUL_A;
      S_MUL_A: begin
        w_m0_start = 1'b1;
`ifdef JAC2AFF_INV_CHECK_EN
        w_m1_start = 1'b1;
        w_m1_a     = r_Z;
`endif
        w_next = S_WAIT_A;
      end
`ifdef JAC2AFF_INV_CHECK_EN
      S_WAIT_A: if (!r_skip && w_m0_rdy && w_m1_rdy) w_next = S_MUL_B;
`else
      S_WAIT_A: if (!r_skip && w_m0_rdy) w_next = S_MUL_B;
`endif
      S_MUL_B: begin
        w_m0_start = 1'b1;
        w_m1_start = 1'b1;
        w_m0_a     = r_X;
        w_m0_b     = r_zi2;
        w_next     = S_WAIT_B;
      end
      S_WAIT_B: if (!r_skip && w_m0_rdy && w_m1_rdy) w_next = S_MUL_C;
      S_MUL_C: begin
        w_m0_start = 1'b1;
        w_m0_a     = r_Y;
        w_m0_b     = r_zi3;
        w_next     = S_WAIT_C;
      end
      S_WAIT_C: if (!r_skip && w_m0_rdy) w_next = S_DONE;
      S_DONE:   if (w_accept) w_next = S_CHK;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_skip  <= 1'b0;
      x_aff   <= '0;
      y_aff   <= '0;
      o_inf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_skip  <= (r_state == S_MUL_A) || (r_state == S_MUL_B) || (r_state == S_MUL_C);
      if (w_accept) o_inf <= 1'b0;
      if (r_state == S_CHK && r_Z == '0) begin
        x_aff <= '0;
        y_aff <= '0;
        o_inf <= 1'b1;
      end
      if (w_take_b) x_aff <= w_m0_res;
      if (w_take_c) y_aff <= w_m0_res;
    end
  end

`ifdef JAC2AFF_INV_CHECK_EN
  logic r_err;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_err <= 1'b0;
    else if (w_accept) r_err <= 1'b0;
    else if (w_take_a) r_err <= (w_m1_res != 256'd1);
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  // Datapath: operand capture, inverter iterations, intermediate powers of zinv
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_X <= X;
      r_Y <= Y;
      r_Z <= Z;
      r_p <= p;
    end
    if (r_state == S_CHK) begin
      r_u  <= r_Z;
      r_v  <= r_p;
      r_x1 <= 256'd1;
      r_x2 <= '0;
    end else if (r_state == S_INV) begin
      if (r_u == 256'd1) r_zinv <= r_x1;
      else if (r_v == 256'd1) r_zinv <= r_x2;
      else if (!r_u[0]) begin
        r_u  <= r_u >> 1;
        r_x1 <= half_mod(r_x1, r_p);
      end else if (!r_v[0]) begin
        r_v  <= r_v >> 1;
        r_x2 <= half_mod(r_x2, r_p);
      end else if (r_u >= r_v) begin
        r_u  <= r_u - r_v;
        r_x1 <= sub_mod(r_x1, r_x2, r_p);
      end else begin
        r_v  <= r_v - r_u;
        r_x2 <= sub_mod(r_x2, r_x1, r_p);
      end
    end
    if (w_take_a) r_zi2 <= w_m0_res;
    if (w_take_b) r_zi3 <= w_m1_res;
  end

  modular_multiplication u_mul0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_m0_start),
    .i_a     (w_m0_a),
    .i_b     (w_m0_b),
    .i_p     (r_p),
    .o_ready (w_m0_rdy),
    .o_result(w_m0_res)
  );

  modular_multiplication u_mul1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_m1_start),
    .i_a     (w_m1_a),
    .i_b     (w_m1_b),
    .i_p     (r_p),
    .o_ready (w_m1_rdy),
    .o_result(w_m1_res)
  );
endmodule

// File: tb/tb_jacobian_to_affine.sv
// Directed and randomized bench for jacobian_to_affine; expected affine points come from Fermat-inverse arithmetic.
module tb_jacobian_to_affine;
  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [255:0] X, Y, Z, P;
  logic [255:0] x_aff, y_aff;
  logic         o_inf, o_busy, o_done, o_err;
  int           n_chk = 0;
  int           n_pass = 0;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  always #5 clk = ~clk;

  jacobian_to_affine dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .X(X), .Y(Y), .Z(Z), .p(P),
    .x_aff(x_aff), .y_aff(y_aff),
    .o_inf(o_inf), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  function automatic logic [255:0] mulmod(input logic [255:0] a, b, m);
    logic [511:0] prod;
    prod = {256'b0, a} * {256'b0, b};
    prod = prod % {256'b0, m};
    return prod[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] a, e, m);
    logic [255:0] r, base;
    r = 256'd1;
    base = a;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, base, m);
      base = mulmod(base, base, m);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_below(input logic [255:0] m);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r % m;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic launch(input logic [255:0] xi, yi, zi, pi);
    bit ok;
    @(negedge clk);
    start = 1'b0;
    X = xi; Y = yi; Z = zi; P = pi;
    @(negedge clk);
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_busy) begin ok = 1'b1; break; end
    end
    chk("busy_rise", {255'b0, ok}, 256'd1);
    chk("done_clear_on_start", {255'b0, o_done}, 256'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!o_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_within_bound", {255'b0, o_done}, 256'd1);
  endtask

  task automatic check_result(input string tag, input logic [255:0] xi, yi, zi, pi);
    logic [255:0] zinv, zi2, zi3, ex, ey;
    if (zi == '0) begin
      ex = '0; ey = '0;
    end else begin
      zinv = powmod(zi, pi - 256'd2, pi);
      zi2  = mulmod(zinv, zinv, pi);
      zi3  = mulmod(zi2, zinv, pi);
      ex   = mulmod(xi, zi2, pi);
      ey   = mulmod(yi, zi3, pi);
    end
    chk({tag, "_x"}, x_aff, ex);
    chk({tag, "_y"}, y_aff, ey);
    chk({tag, "_inf"}, {255'b0, o_inf}, {255'b0, (zi == '0)});
    chk({tag, "_err"}, {255'b0, o_err}, 256'd0);
  endtask

  task automatic run_conv(input string tag, input logic [255:0] xi, yi, zi, pi);
    int cyc;
    launch(xi, yi, zi, pi);
    start = 1'b0;
    wait_done(cyc);
    check_result(tag, xi, yi, zi, pi);
  endtask

  task automatic reset_pulse_and_watch(input string tag, input int watch);
    bit seen;
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk({tag, "_x0"}, x_aff, '0);
    chk({tag, "_y0"}, y_aff, '0);
    chk({tag, "_flags0"}, {252'b0, o_inf, o_busy, o_done, o_err}, '0);
    seen = 1'b0;
    for (int i = 0; i < watch; i++) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    chk({tag, "_no_spurious_done"}, {255'b0, seen}, 256'd0);
  endtask

  initial begin
    logic [255:0] primes [6];
    logic [255:0] pp, xr, yr, zr;
    int cyc;
    primes[0] = 256'd23;
    primes[1] = 256'd101;
    primes[2] = 256'd65521;
    primes[3] = 256'd2147483647;
    primes[4] = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
    primes[5] = P256;

    rst_n = 1'b0; start = 1'b0;
    X = '0; Y = '0; Z = '0; P = 256'd23;
    repeat (3) @(negedge clk);
    chk("rst_x", x_aff, '0);
    chk("rst_y", y_aff, '0);
    chk("rst_flags", {252'b0, o_inf, o_busy, o_done, o_err}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_conv("identity", 256'd5, 256'd7, 256'd1, 256'd23);
    chk("identity_x_const", x_aff, 256'd5);
    chk("identity_y_const", y_aff, 256'd7);
    repeat (5) @(negedge clk);
    chk("identity_done_held", {255'b0, o_done}, 256'd1);

    run_conv("z2", 256'd5, 256'd7, 256'd2, 256'd23);
    chk("z2_x_const", x_aff, 256'd7);
    chk("z2_y_const", y_aff, 256'd21);

    launch(256'd9, 256'd4, 256'd0, 256'd23);
    start = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("inf_fast_done", {255'b0, (o_done && cyc <= 2)}, 256'd1);
    check_result("inf", 256'd9, 256'd4, 256'd0, 256'd23);

    xr = rand_below(256'd101); yr = rand_below(256'd101); zr = 256'd1 + rand_below(256'd100);
    launch(xr, yr, zr, 256'd101);
    wait_done(cyc);
    check_result("hold", xr, yr, zr, 256'd101);
    repeat (20) @(negedge clk);
    chk("hold_no_relaunch", {254'b0, o_done, o_busy}, 256'd2);
    start = 1'b0;

    xr = rand_below(P256); yr = rand_below(P256); zr = 256'd1 + rand_below(P256 - 256'd1);
    launch(xr, yr, zr, P256);
    start = 1'b0;
    repeat (10) @(negedge clk);
    X = '0; Y = '0; Z = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check_result("pulse_in_inv", xr, yr, zr, P256);

    launch(rand_below(P256), rand_below(P256), 256'd3, P256);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset_pulse_and_watch("rst_inv", 1400);

    launch(256'd5, 256'd7, 256'd3, 256'd23);
    start = 1'b0;
    repeat (400) @(negedge clk);
    reset_pulse_and_watch("rst_waitb", 1000);
    run_conv("after_rst", 256'd5, 256'd7, 256'd2, 256'd23);

    for (int t = 0; t < 6; t++) begin
      pp = primes[t];
      xr = rand_below(pp); yr = rand_below(pp); zr = 256'd1 + rand_below(pp - 256'd1);
      run_conv("rand", xr, yr, zr, pp);
    end

`ifdef JAC2AFF_INV_CHECK_EN
    force dut.r_zinv = 256'd5;
    launch(256'd5, 256'd7, 256'd2, 256'd23);
    start = 1'b0;
    wait_done(cyc);
    chk("inv_check_err", {255'b0, o_err}, 256'd1);
    release dut.r_zinv;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
